id_ex_pipe: RTL and testbench

Parametrised ID/EX pipeline stage register with valid/ready flow control, a one-entry skid buffer, synchronous flush-to-bubble and saturating stall/bubble counters. Sits between the decode stage and the execute stage. It carries control fields (EX/MEM/WB), register specifiers, operands and the sign-extended immediate. A stalled EX stage backpressures decode without combinational ready paths, and hazard logic can squash in-flight instructions into NOPs.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_skid_buf.sv | 57 +++++
 rtl/id_ex_pipe.sv | 73 +++++++
 tb/tb_id_ex_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, payload layout and NOP encodings for the ID/EX pipeline register.
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;
  localparam int DEF_EX_W   = 5;
  localparam int DEF_MEM_W  = 2;
  localparam int DEF_WB_W   = 2;
  localparam int DEF_CNT_W  = 16;

  // A bubble carries all-zero control, so downstream sees no side effects.
  localparam logic [DEF_EX_W-1:0]  EX_NOP  = '0;
  localparam logic [DEF_MEM_W-1:0] MEM_NOP = '0;
  localparam logic [DEF_WB_W-1:0]  WB_NOP  = '0;

  // Control fields sit at the top so a bubble clear is one contiguous mask.
  typedef struct packed {
    logic [DEF_EX_W-1:0]   ex;
    logic [DEF_MEM_W-1:0]  mem;
    logic [DEF_WB_W-1:0]   wb;
    logic [DEF_REG_W-1:0]  rs;
    logic [DEF_REG_W-1:0]  rt;
    logic [DEF_REG_W-1:0]  rd;
    logic [DEF_DATA_W-1:0] rd1;
    logic [DEF_DATA_W-1:0] rd2;
    logic [DEF_DATA_W-1:0] imm;
  } id_ex_payload_t;

  localparam int PAYLOAD_W = $bits(id_ex_payload_t);
endpackage

// File: rtl/pipe_skid_buf.sv
// Two-slot (main + skid) pipeline register with registered ready and flush.
// Bits set in CLR_MASK are zeroed whenever main is loaded empty; other bits hold.
module pipe_skid_buf #(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;
  logic         accept, advance;

  // Ready depends only on a flop, so decode never sees a combinational path from execute.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign advance   = !main_valid || out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Slot update: flush beats everything, skid drains into main before new input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= main_data & ~CLR_MASK;
    end else if (advance) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= accept;
        if (accept) skid_data <= in_data;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= in_data;
      end else begin
        main_valid <= 1'b0;
        main_data  <= main_data & ~CLR_MASK;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX stage register: skid-buffered payload, NOP control on bubbles,
// saturating stall and bubble counters.
module id_ex_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W,
  parameter int EX_W   = DEF_EX_W,
  parameter int MEM_W  = DEF_MEM_W,
  parameter int WB_W   = DEF_WB_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_E,
  input  logic              in_valid_D,
  output logic              in_ready_D,
  input  logic [EX_W-1:0]   EX_D,
  input  logic [MEM_W-1:0]  MEM_D,
  input  logic [WB_W-1:0]   WB_D,
  input  logic [REG_W-1:0]  Rs_D,
  input  logic [REG_W-1:0]  Rt_D,
  input  logic [REG_W-1:0]  Rd_D,
  input  logic [DATA_W-1:0] RD1_D,
  input  logic [DATA_W-1:0] RD2_D,
  input  logic [DATA_W-1:0] SignImm_D,
  output logic              out_valid_E,
  input  logic              out_ready_E,
  output logic [EX_W-1:0]   EX_E,
  output logic [MEM_W-1:0]  MEM_E,
  output logic [WB_W-1:0]   WB_E,
  output logic [REG_W-1:0]  Rs_E,
  output logic [REG_W-1:0]  Rt_E,
  output logic [REG_W-1:0]  Rd_E,
  output logic [DATA_W-1:0] RD1_E,
  output logic [DATA_W-1:0] RD2_E,
  output logic [DATA_W-1:0] SignImm_E,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam int CTL_W = EX_W + MEM_W + WB_W;
  localparam int PAY_W = CTL_W + 3*REG_W + 3*DATA_W;
  // Only the control fields are forced to NOP; operands keep their last value.
  localparam logic [PAY_W-1:0] CTL_MASK = {{CTL_W{1'b1}}, {(PAY_W-CTL_W){1'b0}}};

  logic [PAY_W-1:0] pay_d, pay_e;

  assign pay_d = {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D};
  assign {EX_E, MEM_E, WB_E, Rs_E, Rt_E, Rd_E, RD1_E, RD2_E, SignImm_E} = pay_e;

  pipe_skid_buf #(.W(PAY_W), .CLR_MASK(CTL_MASK)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush_E),
    .in_valid  (in_valid_D),
    .in_ready  (in_ready_D),
    .in_data   (pay_d),
    .out_valid (out_valid_E),
    .out_ready (out_ready_E),
    .out_data  (pay_e)
  );

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid_E && !out_ready_E && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (!out_valid_E && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: payloads queued on accept, checked on consume.
module tb_id_ex_pipe;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset, flush_E, in_valid_D, out_ready_E;
  logic [4:0]  EX_D;  logic [1:0] MEM_D, WB_D;
  logic [4:0]  Rs_D, Rt_D, Rd_D;
  logic [31:0] RD1_D, RD2_D, SignImm_D;

  logic        in_ready_D, out_valid_E;
  logic [4:0]  EX_E;  logic [1:0] MEM_E, WB_E;
  logic [4:0]  Rs_E, Rt_E, Rd_E;
  logic [31:0] RD1_E, RD2_E, SignImm_E;
  logic [15:0] stall_cnt, bubble_cnt;

  logic        in_ready3, out_valid3;
  logic [4:0]  EX3;  logic [1:0] MEM3, WB3;
  logic [4:0]  Rs3, Rt3, Rd3;
  logic [31:0] RD1_3, RD2_3, Imm3;
  logic [2:0]  stall3, bubble3;

  id_ex_payload_t sb[$];
  id_ex_payload_t cur;
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk(clk), .reset(reset), .flush_E(flush_E), .in_valid_D(in_valid_D), .in_ready_D(in_ready_D),
    .EX_D(EX_D), .MEM_D(MEM_D), .WB_D(WB_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .out_valid_E(out_valid_E), .out_ready_E(out_ready_E),
    .EX_E(EX_E), .MEM_E(MEM_E), .WB_E(WB_E), .Rs_E(Rs_E), .Rt_E(Rt_E), .Rd_E(Rd_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .SignImm_E(SignImm_E),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt));

  id_ex_pipe #(.CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .flush_E(flush_E), .in_valid_D(in_valid_D), .in_ready_D(in_ready3),
    .EX_D(EX_D), .MEM_D(MEM_D), .WB_D(WB_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .SignImm_D(SignImm_D),
    .out_valid_E(out_valid3), .out_ready_E(out_ready_E),
    .EX_E(EX3), .MEM_E(MEM3), .WB_E(WB3), .Rs_E(Rs3), .Rt_E(Rt3), .Rd_E(Rd3),
    .RD1_E(RD1_3), .RD2_E(RD2_3), .SignImm_E(Imm3),
    .stall_cnt(stall3), .bubble_cnt(bubble3));

  function automatic id_ex_payload_t mk(input logic [7:0] v);
    id_ex_payload_t p;
    p.ex  = {v[3:0], 1'b1};
    p.mem = {1'b1, v[0]};
    p.wb  = {v[1], 1'b1};
    p.rs  = v[4:0];
    p.rt  = v[4:0] ^ 5'h1f;
    p.rd  = v[4:0] + 5'd3;
    p.rd1 = {24'h0, v};
    p.rd2 = {16'hbeef, 8'h00, v};
    p.imm = {{24{v[7]}}, v};
    return p;
  endfunction

  task automatic present(input logic [7:0] v);
    cur = mk(v);
    in_valid_D = 1'b1;
    {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D} = cur;
  endtask

  // One clock: score the handshakes visible now, then advance to the next negedge.
  task automatic cycle();
    id_ex_payload_t exp, obs;
    obs = {EX_E, MEM_E, WB_E, Rs_E, Rt_E, Rd_E, RD1_E, RD2_E, SignImm_E};
    if (out_valid_E && out_ready_E) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++; $display("FAIL sb_underflow got RD1_E=%h expected no entry", RD1_E);
      end else begin
        exp = sb.pop_front();
        if (obs !== exp) begin
          n_bad++; $display("FAIL payload got %h expected %h", obs, exp);
        end
      end
    end
    if (flush_E) sb.delete();
    else if (in_valid_D && in_ready_D) sb.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (out_valid_E !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b expected 0", out_valid_E); end
    n_vec++; if (in_ready_D !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b expected 1", in_ready_D); end
    n_vec++; if ({stall_cnt, bubble_cnt} !== 32'h0) begin n_bad++; $display("FAIL rst_cnt got %h expected 0", {stall_cnt, bubble_cnt}); end
    n_vec++; if ({EX_E, MEM_E, WB_E, RD1_E} !== 41'h0) begin n_bad++; $display("FAIL rst_out got %h expected 0", {EX_E, MEM_E, WB_E, RD1_E}); end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_idle();
    repeat (5) cycle();
    n_vec++; if (bubble_cnt !== 16'd5) begin n_bad++; $display("FAIL idle_bubble got %0d expected 5", bubble_cnt); end
    n_vec++; if ({EX_E, MEM_E, WB_E} !== {EX_NOP, MEM_NOP, WB_NOP}) begin n_bad++; $display("FAIL idle_ctl got %h expected 0", {EX_E, MEM_E, WB_E}); end
  endtask

  task automatic test_back_to_back();
    out_ready_E = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(8'h11 + 8'(i));
      cycle();
      n_vec++; if (out_valid_E !== 1'b1 || RD1_E !== 32'h11 + 32'(i)) begin
        n_bad++; $display("FAIL b2b_out got v=%b RD1=%h expected v=1 RD1=%h", out_valid_E, RD1_E, 32'h11 + 32'(i));
      end
      n_vec++; if (in_ready_D !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b expected 1", in_ready_D); end
    end
    in_valid_D = 1'b0;
    cycle();
    n_vec++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL b2b_stall got %0d expected 0", stall_cnt); end
    n_vec++; if (sb.size() != 0) begin n_bad++; $display("FAIL b2b_drain got %0d expected 0 pending", sb.size()); end
  endtask

  task automatic test_stall();
    out_ready_E = 1'b0;
    present(8'hA0); cycle();
    present(8'hA1); cycle();
    n_vec++; if (in_ready_D !== 1'b0) begin n_bad++; $display("FAIL stall_ready got %b expected 0", in_ready_D); end
    present(8'hA2); cycle(); cycle();
    n_vec++; if (stall_cnt !== 16'd3) begin n_bad++; $display("FAIL stall_cnt got %0d expected 3", stall_cnt); end
    n_vec++; if (RD1_E !== 32'hA0 || out_valid_E !== 1'b1) begin n_bad++; $display("FAIL stall_hold got RD1=%h expected a0", RD1_E); end
    out_ready_E = 1'b1;
    cycle();
    cycle();
    in_valid_D = 1'b0;
    cycle();
    n_vec++; if (sb.size() != 0 || out_valid_E !== 1'b0) begin n_bad++; $display("FAIL stall_drain got %0d pending v=%b expected 0", sb.size(), out_valid_E); end
  endtask

  task automatic test_flush();
    out_ready_E = 1'b0;
    present(8'hB0); cycle();
    present(8'hB1); cycle();
    n_vec++; if (in_ready_D !== 1'b0) begin n_bad++; $display("FAIL flush_full got %b expected 0", in_ready_D); end
    present(8'hB2); flush_E = 1'b1; cycle();
    flush_E = 1'b0; in_valid_D = 1'b0;
    n_vec++; if (out_valid_E !== 1'b0 || in_ready_D !== 1'b1) begin n_bad++; $display("FAIL flush_state got v=%b r=%b expected v=0 r=1", out_valid_E, in_ready_D); end
    n_vec++; if ({EX_E, MEM_E, WB_E} !== 9'h0) begin n_bad++; $display("FAIL flush_ctl got %h expected 0", {EX_E, MEM_E, WB_E}); end
    out_ready_E = 1'b1;
    repeat (3) begin
      cycle();
      n_vec++; if (out_valid_E !== 1'b0) begin n_bad++; $display("FAIL flush_drop got RD1=%h expected no entry", RD1_E); end
    end
    present(8'hC0); cycle();
    in_valid_D = 1'b0; flush_E = 1'b1; cycle();
    flush_E = 1'b0;
    n_vec++; if (out_valid_E !== 1'b0 || in_ready_D !== 1'b1 || sb.size() != 0) begin
      n_bad++; $display("FAIL flush_consume got v=%b r=%b pend=%0d expected 0 1 0", out_valid_E, in_ready_D, sb.size());
    end
  endtask

  task automatic test_saturate();
    out_ready_E = 1'b0;
    present(8'hE0); cycle();
    present(8'hE1); cycle();
    present(8'hE2);
    repeat (10) cycle();
    n_vec++; if (stall3 !== 3'd7) begin n_bad++; $display("FAIL sat_cnt3 got %0d expected 7", stall3); end
    n_vec++; if (stall_cnt !== 16'd16) begin n_bad++; $display("FAIL sat_cnt16 got %0d expected 16", stall_cnt); end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b1;
    #1;
    n_vec++; if (out_valid_E !== 1'b0 || in_ready_D !== 1'b1) begin n_bad++; $display("FAIL arst_vr got v=%b r=%b expected v=0 r=1", out_valid_E, in_ready_D); end
    n_vec++; if ({stall_cnt, bubble_cnt, stall3} !== 35'h0) begin n_bad++; $display("FAIL arst_cnt got %h expected 0", {stall_cnt, bubble_cnt, stall3}); end
    n_vec++; if ({EX_E, MEM_E, WB_E, RD1_E} !== 41'h0) begin n_bad++; $display("FAIL arst_out got %h expected 0", {EX_E, MEM_E, WB_E, RD1_E}); end
    sb.delete();
    in_valid_D = 1'b0; out_ready_E = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    present(8'hF0); cycle();
    in_valid_D = 1'b0; cycle();
    n_vec++; if (bubble_cnt !== 16'd1 || sb.size() != 0) begin n_bad++; $display("FAIL arst_after got bubble=%0d pend=%0d expected 1 0", bubble_cnt, sb.size()); end
  endtask

  initial begin
    reset = 1'b1; flush_E = 1'b0; in_valid_D = 1'b0; out_ready_E = 1'b0;
    cur = '0;
    {EX_D, MEM_D, WB_D, Rs_D, Rt_D, Rd_D, RD1_D, RD2_D, SignImm_D} = '0;
    test_reset();
    test_idle();
    test_back_to_back();
    test_stall();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
